// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: CPU load/store requests in, word-addressed DM port out.
// Sub-word stores use a read-modify-write through a MERGE state. Loads extract the
// addressed lane and sign/zero extend it. Misaligned, illegal-size and out-of-range
// requests are answered with an error response and never touch memory.
module dm_access_ctrl #(
  parameter int unsigned DM_AW     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic             dm_we,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_RESP  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t r_state;
  state_t w_next;

  // Registered request fields (captured on accept)
  logic [DM_AW-1:0] r_addr;
  logic [1:0]       r_lane;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [31:0]      r_wdata;

  // Registered outputs
  logic [31:0]      r_din;
  logic [31:0]      r_rdata;

  logic             w_accept;
  logic             w_in_range;
  logic             w_err;
  logic [31:0]      w_load_val;
  logic [31:0]      w_merge_val;

  // Lane extraction with sign or zero extension for loads.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = sgn ? 32'($signed(b)) : {24'd0, b};
      SZ_HALF: res = sgn ? 32'($signed(h)) : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the current word with right-justified store data.
  function automatic logic [31:0] merge_store(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  size,
    input logic [1:0]  lane
  );
    logic [31:0] res;
    res = old;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) res[31:16] = wd[15:0];
        else         res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_in_range  = (req_addr >> (DM_AW + 2)) == (BASE_ADDR >> (DM_AW + 2));
  assign w_err       = (req_size == SZ_ILL)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                    || !w_in_range;
  assign w_load_val  = load_extract(dm_dout, r_size, r_lane, r_signed);
  assign w_merge_val = merge_store(dm_dout, r_wdata, r_size, r_lane);

  assign dm_addr    = r_addr;
  assign dm_din     = r_din;
  assign resp_rdata = r_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and state-derived strobes
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    dm_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_err)                  w_next = S_ERR;
          else if (!req_we)           w_next = S_RD;
          else if (req_size == SZ_WORD) w_next = S_WR;
          else                        w_next = S_MERGE;
        end
      end
      S_RD:    w_next = S_RESP;
      S_MERGE: w_next = S_WR;
      S_WR: begin
        // A reset arriving in the write cycle must cancel the write.
        dm_we  = !rst;
        w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        w_next     = S_IDLE;
      end
      S_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request field capture; these only matter while a request is in flight
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lane   <= req_addr[1:0];
      r_size   <= req_size;
      r_signed <= req_signed;
      r_wdata  <= req_wdata;
    end
  end

  // Visible registers: DM address, DM write data and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_din   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr[DM_AW+1:2];
        if (req_we && (req_size == SZ_WORD) && !w_err) r_din <= req_wdata;
        // Error responses follow immediately, so clear the result now.
        if (w_err) r_rdata <= '0;
      end
      case (r_state)
        S_RD:    r_rdata <= w_load_val;
        S_MERGE: r_din   <= w_merge_val;
        S_WR:    r_rdata <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: a DM array behind the port, a reference model of memory
// and responses, a per-cycle compare process and literal expectations per scenario.
module tb_dm_access_ctrl;

  localparam int unsigned DM_AW = 10;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic             resp_err;
  logic [31:0]      resp_rdata;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_din;
  logic             dm_we;
  logic [31:0]      dm_dout;

  dm_access_ctrl #(.DM_AW(DM_AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_we(dm_we), .dm_dout(dm_dout)
  );

  always #5 clk = ~clk;

  // Data memory behind the port: combinational read, posedge write
  logic [31:0] dmem [0:(1<<DM_AW)-1];
  assign dm_dout = dmem[dm_addr];
  always @(posedge clk) if (dm_we) dmem[dm_addr] <= dm_din;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model
  typedef struct {
    int          resp_cyc;
    bit          err;
    logic [31:0] rdata;
    bit          has_wr;
    int          wr_cyc;
    int          wr_addr;
    logic [31:0] wr_data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [0:(1<<DM_AW)-1];

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    return (a >> (DM_AW + 2)) != (BASE >> (DM_AW + 2));
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [1:0] sz,
                                         input logic [31:0] a, input bit sg);
    logic [31:0] v;
    v = word >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v & 32'h0000_00FF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'h0000_FFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int          sh;
    sh   = 8 * (a % 4);
    mask = (sz == 2'd0) ? (32'hFF << sh) : (sz == 2'd1) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Record the expected behaviour of a request accepted at edge t.
  task automatic model_accept(input bit we, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd, input int t);
    exp_t e;
    int   idx;
    idx       = int'((a >> 2) % (1 << DM_AW));
    e.err     = m_err(sz, a);
    e.rdata   = 32'd0;
    e.has_wr  = 1'b0;
    e.wr_cyc  = -1;
    e.wr_addr = idx;
    e.wr_data = 32'd0;
    if (e.err) begin
      e.resp_cyc = t;
    end else if (!we) begin
      e.rdata    = m_load(mmem[idx], sz, a, sg);
      e.resp_cyc = t + 1;
    end else begin
      e.has_wr  = 1'b1;
      e.wr_data = m_store(mmem[idx], wd, sz, a);
      mmem[idx] = e.wr_data;
      if (sz == 2'd2) begin
        e.wr_cyc   = t;
        e.resp_cyc = t + 1;
      end else begin
        e.wr_cyc   = t + 1;
        e.resp_cyc = t + 2;
      end
    end
    q.push_back(e);
  endtask

  // Observations kept for the literal expectations
  bit          chk_en = 1'b0;
  bit          got_wr_seen;
  int          got_wr_cyc;
  logic [31:0] got_wr_din;
  logic [31:0] got_wr_addr;
  bit          got_resp_seen;
  int          got_resp_cyc;
  logic [31:0] got_rdata;
  logic        got_err;
  int          t_acc;

  // Compare DUT against the model every cycle, mid-cycle
  always @(negedge clk) begin
    bit ev;
    bit ew;
    if (chk_en) begin
      ev = (q.size() > 0) && (q[0].resp_cyc == cyc);
      ew = (q.size() > 0) && q[0].has_wr && (q[0].wr_cyc == cyc);
      chk("resp_valid", 32'(resp_valid), 32'(ev));
      chk("dm_we", 32'(dm_we), 32'(ew));
      if (dm_we) begin
        got_wr_seen = 1'b1;
        got_wr_cyc  = cyc;
        got_wr_din  = dm_din;
        got_wr_addr = 32'(dm_addr);
      end
      if (resp_valid) begin
        got_resp_seen = 1'b1;
        got_resp_cyc  = cyc;
        got_rdata     = resp_rdata;
        got_err       = resp_err;
      end
      if (ew) begin
        chk("dm_addr", 32'(dm_addr), 32'(q[0].wr_addr));
        chk("dm_din", dm_din, q[0].wr_data);
      end
      if (ev) begin
        chk("resp_err", 32'(resp_err), 32'(q[0].err));
        chk("resp_rdata", resp_rdata, q[0].rdata);
        void'(q.pop_front());
      end
    end
  end

  // Issue one request (called at posedge+1) and wait until it has completed.
  task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int n;
    got_wr_seen   = 1'b0;
    got_resp_seen = 1'b0;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    t_acc = cyc + 1;
    model_accept(we, sz, sg, a, wd, t_acc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << DM_AW); i++) begin
      dmem[i] = 32'd0;
      mmem[i] = 32'd0;
    end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dm_we", 32'(dm_we), 32'd0);
    chk("rst_dm_addr", 32'(dm_addr), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Word store then word load
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    chk("sw_wr_lat", 32'(got_wr_cyc - t_acc), 32'd0);
    chk("sw_wr_addr", got_wr_addr, 32'd4);
    chk("sw_wr_din", got_wr_din, 32'hDEAD_BEEF);
    chk("sw_resp_lat", 32'(got_resp_cyc - t_acc), 32'd1);
    chk("sw_rdata", got_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("lw_rdata", got_rdata, 32'hDEAD_BEEF);
    chk("lw_resp_lat", 32'(got_resp_cyc - t_acc), 32'd1);

    // Byte store read-modify-write, signed/unsigned byte loads
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00A5);
    chk("sb_wr_lat", 32'(got_wr_cyc - t_acc), 32'd1);
    chk("sb_wr_din", got_wr_din, 32'hA522_3344);
    chk("sb_resp_lat", 32'(got_resp_cyc - t_acc), 32'd2);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    chk("lb_13", got_rdata, 32'hFFFF_FFA5);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    chk("lbu_13", got_rdata, 32'h0000_00A5);

    // Half-word loads
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
    chk("lh_12", got_rdata, 32'hFFFF_A522);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0);
    chk("lhu_12", got_rdata, 32'h0000_A522);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'd0);
    chk("lhu_10", got_rdata, 32'h0000_3344);

    // Error cases: misaligned word, misaligned half, illegal size, out of range
    do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'd0);
    chk("err_lw11", 32'(got_err), 32'd1);
    chk("err_lw11_rdata", got_rdata, 32'd0);
    chk("err_lw11_lat", 32'(got_resp_cyc - t_acc), 32'd0);
    do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'd0);
    chk("err_lh13", 32'(got_err), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
    chk("err_size3", 32'(got_err), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h5555_5555);
    chk("err_sw_oor", 32'(got_err), 32'd1);
    chk("err_sw_oor_nowr", 32'(got_wr_seen), 32'd0);

    // Half store aborted by reset in the write cycle; held request waits for IDLE
    got_wr_seen = 1'b0;
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
    chk("abort_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'd0;
    chk("abort_ready_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_ready_wr", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_nowr", 32'(got_wr_seen), 32'd0);
    chk("abort_idle_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    chk("abort_word_kept", got_rdata, 32'hA522_3344);
    chk("abort_lw_lat", 32'(got_resp_cyc - t_acc), 32'd1);

    // More lanes and the top of the memory
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
    chk("sh_12_din", got_wr_din, 32'h1234_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
    chk("lbu_11", got_rdata, 32'h0000_0033);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'd0);
    chk("lb_12", got_rdata, 32'h0000_0034);
    do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFF_FF80);
    chk("sb_10_din", got_wr_din, 32'h1234_3380);
    do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'd0);
    chk("lb_10", got_rdata, 32'hFFFF_FF80);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'h8000_0001);
    chk("sw_ffc_addr", got_wr_addr, 32'd1023);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFE, 32'd0);
    chk("lh_ffe", got_rdata, 32'hFFFF_8000);
    do_req(1'b0, 2'd0, 1'b1, 32'hFFC, 32'd0);
    chk("lb_ffc", got_rdata, 32'h0000_0001);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
